// File: rtl/alu_sum_arb_pkg.sv
// ============================================================================
// alu_sum_arb_pkg -- FSM state encoding and default width for alu_sum_arbiter
// Rev 1.0 -- initial release
// ============================================================================
`default_nettype none

package alu_sum_arb_pkg;

   localparam int         c_defaultWidth = 32;

   localparam logic [1:0] c_stIdle = 2'd0;
   localparam logic [1:0] c_stExec = 2'd1;
   localparam logic [1:0] c_stResp = 2'd2;

   typedef enum logic [1:0] {
      IDLE = c_stIdle,
      EXEC = c_stExec,
      RESP = c_stResp
   } state_t;

endpackage

`default_nettype wire

// File: rtl/alu_sum_core.sv
// ============================================================================
// alu_sum_core -- combinational WIDTH-bit adder with carry-out and overflow
// Rev 1.0 -- initial release
// ============================================================================
`default_nettype none

module alu_sum_core
   import alu_sum_arb_pkg::*;
#(
   parameter int WIDTH = c_defaultWidth
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] sum,
   output logic             carry,
   output logic             ovf
);

   logic [WIDTH:0] w_full;

   assign w_full = {1'b0, a} + {1'b0, b};
   assign sum    = w_full[WIDTH-1:0];
   assign carry  = w_full[WIDTH];
   // Signed overflow: like-signed operands producing a result of the other sign
   assign ovf    = (a[WIDTH-1] == b[WIDTH-1]) && (w_full[WIDTH-1] != a[WIDTH-1]);

endmodule

`default_nettype wire

// File: rtl/alu_sum_arbiter.sv
// ============================================================================
// alu_sum_arbiter -- two requesters sharing one adder (IDLE/EXEC/RESP FSM)
// Define ALU_SUM_ARB_RR_EN for round-robin; default is fixed priority to req0.
// Rev 1.0 -- initial release
// ============================================================================
`default_nettype none

module alu_sum_arbiter
   import alu_sum_arb_pkg::*;
#(
   parameter int WIDTH = c_defaultWidth
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   output logic             req0_ready,
   input  logic             req1_valid,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic             req1_ready,
   output logic             rsp_valid,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_sum,
   output logic             rsp_carry,
   output logic             rsp_ovf,
   input  logic             rsp_ready
);

   state_t           r_state;
   state_t           w_nextState;
   logic [WIDTH-1:0] r_opA;
   logic [WIDTH-1:0] r_opB;
   logic             r_opId;
   logic             w_grant1;
   logic             w_accept;
   logic [WIDTH-1:0] w_sum;
   logic             w_carry;
   logic             w_ovf;
   logic             r_rspId;
   logic [WIDTH-1:0] r_rspSum;
   logic             r_rspCarry;
   logic             r_rspOvf;

`ifdef ALU_SUM_ARB_RR_EN
   logic r_lastGrant;

   // Reset value 1 makes requester 0 win the first contested grant
   always_ff @(posedge clk) begin
      if (!rst_n)
         r_lastGrant <= 1'b1;
      else if (w_accept)
         r_lastGrant <= w_grant1;
   end

   assign w_grant1 = req1_valid && (!req0_valid || !r_lastGrant);
`else
   assign w_grant1 = req1_valid && !req0_valid;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n)
         r_state <= IDLE;
      else
         r_state <= w_nextState;
   end

   always_comb begin
      w_nextState = r_state;
      w_accept    = 1'b0;
      req0_ready  = 1'b0;
      req1_ready  = 1'b0;
      case (r_state)
         IDLE: begin
            w_accept   = rst_n && (req0_valid || req1_valid);
            req0_ready = w_accept && !w_grant1;
            req1_ready = w_accept && w_grant1;
            if (w_accept)
               w_nextState = EXEC;
         end
         EXEC:    w_nextState = RESP;
         RESP: begin
            if (rsp_ready)
               w_nextState = IDLE;
         end
         default: w_nextState = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_opA      <= '0;
         r_opB      <= '0;
         r_opId     <= 1'b0;
         r_rspId    <= 1'b0;
         r_rspSum   <= '0;
         r_rspCarry <= 1'b0;
         r_rspOvf   <= 1'b0;
      end else begin
         if (w_accept) begin
            r_opA  <= w_grant1 ? req1_a : req0_a;
            r_opB  <= w_grant1 ? req1_b : req0_b;
            r_opId <= w_grant1;
         end
         if (r_state == EXEC) begin
            r_rspId    <= r_opId;
            r_rspSum   <= w_sum;
            r_rspCarry <= w_carry;
            r_rspOvf   <= w_ovf;
         end
      end
   end

   alu_sum_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .a     (r_opA),
      .b     (r_opB),
      .sum   (w_sum),
      .carry (w_carry),
      .ovf   (w_ovf)
   );

   assign rsp_valid = (r_state == RESP);
   assign rsp_id    = r_rspId;
   assign rsp_sum   = r_rspSum;
   assign rsp_carry = r_rspCarry;
   assign rsp_ovf   = r_rspOvf;

endmodule

`default_nettype wire

// File: tb/tb_alu_sum_arbiter.sv
// ============================================================================
// tb_alu_sum_arbiter -- transaction-level model checked every cycle, plus
// directed literal cases. Honours ALU_SUM_ARB_RR_EN like the design.
// Rev 1.0 -- initial release
// ============================================================================
`default_nettype none

module tb_alu_sum_arbiter;

   localparam int WIDTH = 32;
`ifdef ALU_SUM_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif
   localparam longint SMAX = (longint'(1) <<< (WIDTH-1)) - 1;
   localparam longint SMIN = -(longint'(1) <<< (WIDTH-1));

   logic             clk = 1'b0;
   logic             rst_n;
   logic             req0_valid, req1_valid, req0_ready, req1_ready;
   logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
   logic             rsp_valid, rsp_id, rsp_carry, rsp_ovf, rsp_ready;
   logic [WIDTH-1:0] rsp_sum;

   always #5 clk = ~clk;

   alu_sum_arbiter #(.WIDTH(WIDTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_sum(rsp_sum),
      .rsp_carry(rsp_carry), .rsp_ovf(rsp_ovf), .rsp_ready(rsp_ready)
   );

   int nChecks = 0;
   int nErrors = 0;

   // Model: at most one transaction in flight; result visible two cycles after accept
   bit               mBusy, mId, mLast, mZero;
   int               mAge;
   logic [WIDTH-1:0] mA, mB;

   logic             sRdy0, sRdy1, sVal, sId, sC, sO;
   logic [WIDTH-1:0] sSum;
   bit               dutGrants[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      nChecks++;
      if (act !== exp) begin
         nErrors++;
         $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
      end
   endtask

   // {ovf, carry, sum} from plain 64-bit arithmetic
   function automatic logic [WIDTH+1:0] refAdd(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      longint unsigned u;
      longint          s;
      u = longint'(a) + longint'(b);
      s = longint'($signed(a)) + longint'($signed(b));
      refAdd = {(s > SMAX) || (s < SMIN), u[WIDTH], u[WIDTH-1:0]};
   endfunction

   task automatic step();
      logic [WIDTH+1:0] r;
      bit               expAcc, g1;
      @(negedge clk);
      sRdy0 = req0_ready; sRdy1 = req1_ready; sVal = rsp_valid;
      sId = rsp_id; sSum = rsp_sum; sC = rsp_carry; sO = rsp_ovf;
      expAcc = rst_n && !mBusy && (req0_valid || req1_valid);
      g1     = req1_valid && (!req0_valid || (RR && !mLast));
      chk("req0_ready", sRdy0, expAcc && !g1);
      chk("req1_ready", sRdy1, expAcc && g1);
      chk("rsp_valid", sVal, mBusy && mAge >= 2);
      if (sRdy1) dutGrants.push_back(1'b1);
      else if (sRdy0) dutGrants.push_back(1'b0);
      if (mBusy && mAge >= 2) begin
         r = refAdd(mA, mB);
         chk("rsp_id", sId, mId);
         chk("rsp_sum", sSum, r[WIDTH-1:0]);
         chk("rsp_carry", sC, r[WIDTH]);
         chk("rsp_ovf", sO, r[WIDTH+1]);
      end else if (mZero) begin
         chk("rsp_zero", {sId, sC, sO, sSum}, 0);
      end
      @(posedge clk);
      if (!rst_n) begin
         mBusy = 0; mLast = 1; mZero = 1; mAge = 0;
      end else if (mBusy) begin
         if (mAge >= 2 && rsp_ready) mBusy = 0;
         else if (mAge < 2) begin
            mAge++;
            if (mAge == 2) mZero = 0;
         end
      end else if (expAcc) begin
         mBusy = 1; mAge = 1; mId = g1; mLast = g1;
         mA = g1 ? req1_a : req0_a;
         mB = g1 ? req1_b : req0_b;
      end
      #1;
   endtask

   task automatic doReset();
      rst_n = 0; req0_valid = 0; req1_valid = 0;
      step(); step();
      rst_n = 1;
   endtask

   task automatic txn(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic [WIDTH-1:0] eSum, input bit eC, input bit eO);
      int acc;
      bit done;
      acc = -1; done = 0;
      req0_valid = 1; req0_a = a; req0_b = b; req1_valid = 0; rsp_ready = 1;
      for (int i = 0; i < 10 && !done; i++) begin
         step();
         if (acc < 0 && sRdy0) begin
            acc = i; req0_valid = 0;
         end else if (acc >= 0 && sVal) begin
            done = 1;
            chk({tag, "_latency"}, i - acc, 2);
            chk({tag, "_id"}, sId, 0);
            chk({tag, "_sum"}, sSum, eSum);
            chk({tag, "_carry"}, sC, eC);
            chk({tag, "_ovf"}, sO, eO);
         end
      end
      if (!done) begin
         nChecks++; nErrors++;
         $display("FAIL %s_timeout: got no response required response within 10 cycles", tag);
      end
      req0_valid = 0;
      step();
   endtask

   function automatic logic [WIDTH-1:0] pickOperand();
      logic [WIDTH-1:0] edges [4];
      edges[0] = '0; edges[1] = '1;
      edges[2] = {1'b0, {(WIDTH-1){1'b1}}}; edges[3] = {1'b1, {(WIDTH-1){1'b0}}};
      if ($urandom_range(3) == 0) return edges[$urandom_range(3)];
      return $urandom;
   endfunction

   initial begin
      logic [WIDTH-1:0] holdSum;
      bit               got;
      rst_n = 0; req0_valid = 0; req1_valid = 0; rsp_ready = 0;
      req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
      repeat (3) @(posedge clk);
      #1;
      mBusy = 0; mLast = 1; mZero = 1; mAge = 0; mId = 0; mA = '0; mB = '0;

      // Requests during reset must not be acknowledged
      req0_valid = 1; req1_valid = 1;
      step();
      chk("reset_no_ready", {sRdy0, sRdy1}, 0);
      req0_valid = 0; req1_valid = 0; rst_n = 1;
      step();
      chk("reset_rsp_valid", sVal, 0);
      chk("reset_rsp_fields", {sId, sC, sO, sSum}, 0);

      txn("simple", 32'h0000_0001, 32'h0000_0010, 32'h0000_0011, 1'b0, 1'b0);
      txn("carry",  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0);
      txn("ovf",    32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1);
      txn("negovf", 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b1);

      // Continuous contention from a fresh reset
      doReset();
      dutGrants.delete();
      req0_valid = 1; req1_valid = 1; rsp_ready = 1;
      req0_a = 32'h10; req0_b = 32'h1; req1_a = 32'h20; req1_b = 32'h2;
      repeat (12) step();
      chk("arb_count", dutGrants.size(), 4);
      for (int i = 0; i < 4 && i < dutGrants.size(); i++)
         chk("arb_grant", dutGrants[i], RR ? (i % 2) : 0);
      req0_valid = 0; req1_valid = 0;
      repeat (3) step();

      // Backpressure in RESP
      rsp_ready = 0; req0_valid = 1; req0_a = 32'h1234_5678; req0_b = 32'h1111_1111;
      got = 0;
      for (int i = 0; i < 6 && !got; i++) begin
         step();
         if (sRdy0) req0_valid = 0;
         got = sVal;
      end
      chk("bp_reached_resp", got, 1);
      holdSum = sSum;
      req0_valid = 1; req1_valid = 1;
      repeat (5) begin
         step();
         chk("bp_hold_valid", sVal, 1);
         chk("bp_hold_sum", sSum, holdSum);
         chk("bp_no_ready", {sRdy0, sRdy1}, 0);
      end
      rsp_ready = 1;
      step();
      step();
      chk("bp_release_accept", sRdy0 | sRdy1, 1);
      req0_valid = 0; req1_valid = 0;
      repeat (4) step();

      // Reset while the operation is in EXEC
      req0_valid = 1; req0_a = 32'h0000_00AA; req0_b = 32'h0000_0055;
      step();
      chk("rx_accept", sRdy0, 1);
      req0_valid = 0; rst_n = 0;
      step();
      rst_n = 1;
      repeat (3) begin
         step();
         chk("rx_no_rsp", sVal, 0);
         chk("rx_zero", {sId, sC, sO, sSum}, 0);
      end
      req0_valid = 1; req1_valid = 1;
      step();
      chk("rx_first_grant0", {sRdy1, sRdy0}, 2'b01);
      req0_valid = 0; req1_valid = 0;
      repeat (4) step();

      // Randomized traffic with occasional resets
      for (int c = 0; c < 3000; c++) begin
         rst_n      = ($urandom_range(199) != 0);
         req0_valid = $urandom_range(1);
         req1_valid = $urandom_range(1);
         req0_a = pickOperand(); req0_b = pickOperand();
         req1_a = pickOperand(); req1_b = pickOperand();
         rsp_ready  = ($urandom_range(3) != 0);
         step();
      end

      $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got no completion required finish before time limit");
      $fatal(1, "watchdog expired");
   end

endmodule

`default_nettype wire
